fir_result_tx: RTL and testbench
================================

Name: fir_result_tx

Overview:
- Transmit end of the FIR output interface.
- Accepts one floatType result per clock from FIR_top and keeps every DECIM-th valid result.
- Buffers kept results in a small FIFO and serializes each word MSB-byte-first over a byte-wide valid/ready link to the host/capture side.
- The filter cannot be stalled, so buffer overflow drops samples and reports the loss instead of back-pressuring.

Parameters:
- WORD_W, 32: result word width; equals $bits(floatType) at instantiation; must be a multiple of BYTE_W.
- BYTE_W, 8: link data width.
- DEPTH, 8: FIFO depth in words; power of 2, at least 2.
- DECIM, 1: keep 1 of every DECIM valid inputs; at least 1.
- CNT_W, 16: width of the drop counter.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: asynchronous, active-low reset.
- in, in, WORD_W: FIR result (floatType bits).
- in_valid, in, 1: in is a valid result this cycle.
- tx_data, out, BYTE_W: current link byte.
- tx_valid, out, 1: tx_data is valid.
- tx_ready, in, 1: sink accepts the byte this cycle.
- tx_last, out, 1: current byte is the final (LSB) byte of a word.
- fill, out, $clog2(DEPTH)+1: number of words in the FIFO.
- overflow, out, 1: sticky flag, set when a kept word is dropped.
- drop_cnt, out, CNT_W: saturating count of dropped words.
- clr_ovf, in, 1: synchronous clear of overflow and drop_cnt.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: tx_valid=0, tx_data=0, tx_last=0, fill=0, overflow=0, drop_cnt=0.
  - Internal: FSM=IDLE, decimation counter=0, FIFO pointers=0.
  - Reset mid-word discards the partial word and the FIFO contents; no tx_last is emitted for it.
- Decimation:
  - The counter advances only on in_valid and wraps at DECIM-1.
  - A word is kept when in_valid=1 and counter==0, so the first valid after reset is kept.
  - DECIM=1 keeps every valid input.
- Push:
  - A kept word is written if fill<DEPTH, or if fill==DEPTH and a pop occurs in the same cycle.
  - Otherwise the word is dropped: overflow<=1, and drop_cnt increments, saturating at 2^CNT_W-1.
  - clr_ovf and a drop in the same cycle: overflow=1, drop_cnt=1.
- Pop:
  - Occurs when the FSM loads the shift register.
  - Simultaneous push and pop leaves fill unchanged.
- FSM, NB = WORD_W/BYTE_W:
  - IDLE: tx_valid=0. If fill>0, pop the head into the shift register, idx=0, go to SEND.
  - SEND: tx_valid=1, tx_data = word byte at idx, MSB byte first; tx_last=(idx==NB-1).
  - SEND, tx_ready=1, idx<NB-1: idx+1.
  - SEND, tx_ready=1, idx==NB-1, fill>0: pop and load the next word, idx=0, stay in SEND. Back-to-back words have no idle gap.
  - SEND, tx_ready=1, idx==NB-1, fill==0: go to IDLE.
  - SEND, tx_ready=0: tx_data, tx_last and tx_valid hold stable; tx_valid never drops before handshake.
- Latency: a word kept at edge E0 is in the FIFO after E0, is loaded at E1 (FSM idle), and tx_valid is high after E1.
- Throughput: sustained link rate is 1 word per NB cycles. With DECIM < NB and continuous in_valid the FIFO overflows; that is expected and must be reported.
- tx_ready is ignored while tx_valid=0.

Decomposition:
- Shared package:
  - txState_t enum {IDLE, SEND}.
  - Function nbytes(WORD_W, BYTE_W).
  - Elaboration checks: WORD_W % BYTE_W == 0, DEPTH a power of 2, DECIM >= 1.
- Sub-module result_fifo:
  - Synchronous FIFO, parameters WIDTH and DEPTH.
  - Ports: push, pop, wdata, rdata (head, first-word-fall-through), count.
  - Same clk/rst convention: asynchronous, active-low.
- Top level holds the decimation counter, drop logic and serializer FSM.

Test Plan:
- Single word: in=32'h3F80_0000 one cycle, tx_ready=1.
  - tx_valid rises 2 edges later.
  - Bytes 3F,80,00,00 on 4 consecutive cycles; tx_last only on 00 (4th); then tx_valid=0.
- Backpressure: 2 words 32'h1122_3344 and 32'h5566_7788, tx_ready toggling 1010.
  - Bytes 11..88 in order; each byte stable while tx_ready=0.
  - No gap between 44 and 55; fill reaches 1 then 0.
- Overflow: in_valid continuous for 20 cycles, DECIM=1, DEPTH=8, tx_ready=0.
  - One word in the shift register, fill=8, drop_cnt=11, overflow=1.
  - clr_ovf pulse -> overflow=0, drop_cnt=0.
- Decimation: DECIM=4, inputs 1..12 (WORD_W=32), tx_ready=1.
  - Transmitted words 1, 5, 9 only.
  - A cycle with in_valid=0 does not advance the counter.
- Reset mid-word: rst=0 asynchronously after byte 2 of a 4-byte word.
  - All outputs 0 immediately, before the next edge.
  - After rst=1 a new word is sent from its MSB byte; no stale bytes.
- Push/pop collision: fill=8 and the last byte is accepted in the same cycle a kept word arrives.
  - Word stored, no drop, fill stays 8.

Source files
------------

// File: rtl/fir_result_tx_pkg.sv
// Shared types and helpers for the FIR result transmitter.
package fir_result_tx_pkg;

   // Serializer states.
   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } txState_t;

   // Number of link bytes per result word.
   function automatic int unsigned nbytes(input int unsigned word_w, input int unsigned byte_w);
      return word_w / byte_w;
   endfunction

   // True when v is a non-zero power of two.
   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/fir_result_tx_if.sv
// Result input and byte-wide valid/ready link between the transmitter and its host.
interface fir_result_tx_if #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned BYTE_W = 8
) ();

   logic [WORD_W-1:0] in;
   logic              in_valid;
   logic [BYTE_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              tx_last;

   // Transmitter side: consumes results, drives the link.
   modport master (
      input  in,
      input  in_valid,
      input  tx_ready,
      output tx_data,
      output tx_valid,
      output tx_last
   );

   // Host side: supplies results, receives the link.
   modport slave (
      output in,
      output in_valid,
      output tx_ready,
      input  tx_data,
      input  tx_valid,
      input  tx_last
   );

endinterface

// File: rtl/fir_result_tx_result_fifo.sv
// Word FIFO with first-word-fall-through head; caller never pops when empty and only
// pushes into a full FIFO together with a pop.
module result_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;

   // Storage array; no reset needed, validity is tracked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping; push+pop leaves count unchanged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata = mem[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/fir_result_tx.sv
// Transmit end of the FIR output: decimates results, buffers them, and serializes each
// word MSB byte first. The filter cannot stall, so a full buffer drops and counts words.
module fir_result_tx
   import fir_result_tx_pkg::*;
#(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned BYTE_W = 8,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned DECIM  = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   fir_result_tx_if.master        bus,
   output logic [$clog2(DEPTH):0] fill,
   output logic                   overflow,
   output logic [CNT_W-1:0]       drop_cnt,
   input  logic                   clr_ovf
);

   localparam int unsigned NB      = nbytes(WORD_W, BYTE_W);
   localparam int unsigned IDX_W   = (NB > 1) ? $clog2(NB) : 1;
   localparam int unsigned DCNT_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int unsigned FILL_W  = $clog2(DEPTH) + 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NB - 1);
   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);

   if (WORD_W % BYTE_W != 0) begin : g_bad_word_w
      $error("WORD_W must be a multiple of BYTE_W");
   end
   if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
      $error("DEPTH must be a power of 2 and at least 2");
   end
   if (DECIM < 1) begin : g_bad_decim
      $error("DECIM must be at least 1");
   end

   logic [DCNT_W-1:0] dcnt_q;
   logic              keep;
   logic              push;
   logic              pop;
   logic              drop;
   logic              full;
   logic              word_done;
   logic [WORD_W-1:0] fifo_rdata;
   logic [FILL_W-1:0] fifo_count;

   txState_t          state_q;
   logic [IDX_W-1:0]  idx_q;
   logic [WORD_W-1:0] shreg_q;
   logic [WORD_W-1:0] shreg_next;
   logic [BYTE_W-1:0] tx_data_q;
   logic              tx_valid_q;
   logic              tx_last_q;
   logic              overflow_q;
   logic [CNT_W-1:0]  drop_cnt_q;

   // Decimation counter: advances only on valid inputs, wraps at DECIM-1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dcnt_q <= '0;
      end else if (bus.in_valid) begin
         dcnt_q <= (dcnt_q == DCNT_LAST) ? '0 : dcnt_q + 1'b1;
      end
   end

   // Pop mirrors the FSM load conditions; a push into a full FIFO rides on a same-cycle pop.
   always_comb begin
      keep      = bus.in_valid && (dcnt_q == '0);
      full      = (fifo_count == FILL_W'(DEPTH));
      word_done = (state_q == SEND) && bus.tx_ready && (idx_q == LAST_IDX);
      pop       = (fifo_count != '0) && ((state_q == IDLE) || word_done);
      push      = keep && (!full || pop);
      drop      = keep && !push;
      shreg_next = shreg_q << BYTE_W;
   end

   result_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (bus.in),
      .rdata (fifo_rdata),
      .count (fifo_count)
   );

   // Sticky overflow and saturating drop count; a drop wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else if (clr_ovf) begin
         overflow_q <= drop;
         drop_cnt_q <= drop ? CNT_W'(1) : '0;
      end else if (drop) begin
         overflow_q <= 1'b1;
         if (drop_cnt_q != '1) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
         end
      end
   end

   // Serializer FSM with registered link outputs; outputs hold while tx_ready is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         shreg_q    <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         tx_last_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (fifo_count != '0) begin
                  state_q    <= SEND;
                  idx_q      <= '0;
                  shreg_q    <= fifo_rdata;
                  tx_data_q  <= fifo_rdata[WORD_W-1 -: BYTE_W];
                  tx_valid_q <= 1'b1;
                  tx_last_q  <= (NB == 1);
               end
            end
            SEND: begin
               if (bus.tx_ready) begin
                  if (idx_q != LAST_IDX) begin
                     idx_q     <= idx_q + 1'b1;
                     shreg_q   <= shreg_next;
                     tx_data_q <= shreg_next[WORD_W-1 -: BYTE_W];
                     tx_last_q <= ((idx_q + 1'b1) == LAST_IDX);
                  end else if (fifo_count != '0) begin
                     // Back-to-back word: reload without an idle cycle.
                     idx_q      <= '0;
                     shreg_q    <= fifo_rdata;
                     tx_data_q  <= fifo_rdata[WORD_W-1 -: BYTE_W];
                     tx_valid_q <= 1'b1;
                     tx_last_q  <= (NB == 1);
                  end else begin
                     state_q    <= IDLE;
                     tx_data_q  <= '0;
                     tx_valid_q <= 1'b0;
                     tx_last_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q    <= IDLE;
               tx_valid_q <= 1'b0;
               tx_last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.tx_data  = tx_data_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.tx_last  = tx_last_q;
   assign fill         = fifo_count;
   assign overflow     = overflow_q;
   assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_fir_result_tx.sv
// Directed self-checking bench for fir_result_tx (DECIM=1 and DECIM=4 instances).
module tb_fir_result_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  fill, fill4;
   logic        overflow, overflow4;
   logic [15:0] drop_cnt, drop_cnt4;
   logic        clr_ovf, clr_ovf4;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] rx_q[$];
   logic [31:0] rx4_q[$];
   logic [31:0] acc4;

   fir_result_tx_if #(.WORD_W(32), .BYTE_W(8)) bus ();
   fir_result_tx_if #(.WORD_W(32), .BYTE_W(8)) bus4 ();

   fir_result_tx #(
      .WORD_W (32), .BYTE_W (8), .DEPTH (8), .DECIM (1), .CNT_W (16)
   ) dut (
      .clk (clk), .rst (rst), .bus (bus), .fill (fill),
      .overflow (overflow), .drop_cnt (drop_cnt), .clr_ovf (clr_ovf)
   );

   fir_result_tx #(
      .WORD_W (32), .BYTE_W (8), .DEPTH (8), .DECIM (4), .CNT_W (16)
   ) dut4 (
      .clk (clk), .rst (rst), .bus (bus4), .fill (fill4),
      .overflow (overflow4), .drop_cnt (drop_cnt4), .clr_ovf (clr_ovf4)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   // Word assembler for the DECIM=4 instance; sampled on the falling edge.
   always @(negedge clk) begin
      if (rst && bus4.tx_valid && bus4.tx_ready) begin
         acc4 = {acc4[23:0], bus4.tx_data};
         if (bus4.tx_last) rx4_q.push_back(acc4);
      end
   end

   typedef struct {
      logic [31:0] din;
      logic        vld;
      logic        rdy;
      logic        exp_valid;
      logic [7:0]  exp_data;
      logic        exp_last;
      logic [3:0]  exp_fill;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: act=%h req=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [31:0] d, input logic v, input logic r, input logic ev,
                      input logic [7:0] ed, input logic el, input logic [3:0] ef);
      vec_t t;
      t.din = d; t.vld = v; t.rdy = r;
      t.exp_valid = ev; t.exp_data = ed; t.exp_last = el; t.exp_fill = ef;
      vq.push_back(t);
   endtask

   // Collect words from the DECIM=1 instance with tx_ready held high until it goes quiet.
   task automatic drain(input int max_cyc, output int nbytes_seen);
      logic [31:0] cur;
      bit done;
      cur = '0;
      done = 0;
      nbytes_seen = 0;
      rx_q.delete();
      bus.tx_ready = 1'b1;
      for (int c = 0; c < max_cyc; c++) begin
         if (bus.tx_valid) begin
            cur = {cur[23:0], bus.tx_data};
            nbytes_seen++;
            if (bus.tx_last) rx_q.push_back(cur);
         end else if (fill == 0 && c > 1) begin
            done = 1;
            break;
         end
         tick();
      end
      if (!done) chk("drain_timeout", 32'd1, 32'd0);
      bus.tx_ready = 1'b0;
   endtask

   initial begin
      int nb;
      logic [31:0] exp_w;

      rst = 1'b0;
      bus.in = '0;  bus.in_valid = 1'b0;  bus.tx_ready = 1'b0;  clr_ovf = 1'b0;
      bus4.in = '0; bus4.in_valid = 1'b0; bus4.tx_ready = 1'b1; clr_ovf4 = 1'b0;
      acc4 = '0;
      tick();
      tick();
      chk("rst_valid", 32'(bus.tx_valid), 32'd0);
      chk("rst_data", 32'(bus.tx_data), 32'd0);
      chk("rst_last", 32'(bus.tx_last), 32'd0);
      chk("rst_fill", 32'(fill), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      rst = 1'b1;
      tick();

      // Single word, then two words with tx_ready toggling.
      add(32'h3F80_0000, 1, 1, 0, 8'h00, 0, 1);
      add(32'h0,         0, 1, 1, 8'h3F, 0, 0);
      add(32'h0,         0, 1, 1, 8'h80, 0, 0);
      add(32'h0,         0, 1, 1, 8'h00, 0, 0);
      add(32'h0,         0, 1, 1, 8'h00, 1, 0);
      add(32'h0,         0, 1, 0, 8'h00, 0, 0);
      add(32'h1122_3344, 1, 0, 0, 8'h00, 0, 1);
      add(32'h5566_7788, 1, 0, 1, 8'h11, 0, 1);
      add(32'h0,         0, 1, 1, 8'h22, 0, 1);
      add(32'h0,         0, 0, 1, 8'h22, 0, 1);
      add(32'h0,         0, 1, 1, 8'h33, 0, 1);
      add(32'h0,         0, 0, 1, 8'h33, 0, 1);
      add(32'h0,         0, 1, 1, 8'h44, 1, 1);
      add(32'h0,         0, 0, 1, 8'h44, 1, 1);
      add(32'h0,         0, 1, 1, 8'h55, 0, 0);
      add(32'h0,         0, 0, 1, 8'h55, 0, 0);
      add(32'h0,         0, 1, 1, 8'h66, 0, 0);
      add(32'h0,         0, 0, 1, 8'h66, 0, 0);
      add(32'h0,         0, 1, 1, 8'h77, 0, 0);
      add(32'h0,         0, 0, 1, 8'h77, 0, 0);
      add(32'h0,         0, 1, 1, 8'h88, 1, 0);
      add(32'h0,         0, 0, 1, 8'h88, 1, 0);
      add(32'h0,         0, 1, 0, 8'h00, 0, 0);

      for (int i = 0; i < vq.size(); i++) begin
         bus.in = vq[i].din;
         bus.in_valid = vq[i].vld;
         bus.tx_ready = vq[i].rdy;
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(bus.tx_valid), 32'(vq[i].exp_valid));
         if (vq[i].exp_valid) begin
            chk($sformatf("vec%0d_data", i), 32'(bus.tx_data), 32'(vq[i].exp_data));
            chk($sformatf("vec%0d_last", i), 32'(bus.tx_last), 32'(vq[i].exp_last));
         end
         chk($sformatf("vec%0d_fill", i), 32'(fill), 32'(vq[i].exp_fill));
      end
      bus.in_valid = 1'b0;
      bus.tx_ready = 1'b0;

      // Overflow: 20 continuous inputs with the link stalled.
      for (int i = 0; i < 20; i++) begin
         bus.in = 32'h0101_0101 * (i + 1);
         bus.in_valid = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      chk("ovf_fill", 32'(fill), 32'd8);
      chk("ovf_drop", 32'(drop_cnt), 32'd11);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_valid", 32'(bus.tx_valid), 32'd1);
      chk("ovf_data", 32'(bus.tx_data), 32'h01);

      // Collision: last byte accepted while a kept word arrives at fill==8.
      bus.tx_ready = 1'b1;
      tick(); tick(); tick();
      chk("col_last_before", 32'(bus.tx_last), 32'd1);
      bus.in = 32'hAABB_CCDD;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.tx_ready = 1'b0;
      chk("col_fill", 32'(fill), 32'd8);
      chk("col_drop", 32'(drop_cnt), 32'd11);
      chk("col_data", 32'(bus.tx_data), 32'h02);
      chk("col_last", 32'(bus.tx_last), 32'd0);

      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("clr_flag", 32'(overflow), 32'd0);
      chk("clr_drop", 32'(drop_cnt), 32'd0);

      // Clear and drop in the same cycle.
      clr_ovf = 1'b1;
      bus.in = 32'hDEAD_BEEF;
      bus.in_valid = 1'b1;
      tick();
      clr_ovf = 1'b0;
      bus.in_valid = 1'b0;
      chk("clrdrop_flag", 32'(overflow), 32'd1);
      chk("clrdrop_drop", 32'(drop_cnt), 32'd1);

      drain(200, nb);
      chk("drain_words", 32'(rx_q.size()), 32'd9);
      chk("drain_bytes", 32'(nb), 32'd36);
      for (int k = 0; k < 9; k++) begin
         exp_w = (k < 8) ? 32'h0101_0101 * (k + 2) : 32'hAABB_CCDD;
         if (k < rx_q.size()) chk($sformatf("drain_w%0d", k), rx_q[k], exp_w);
      end

      // Decimation by 4 on the second instance, with an idle gap that must not count.
      for (int i = 1; i <= 12; i++) begin
         bus4.in = 32'(i);
         bus4.in_valid = 1'b1;
         tick();
         if (i == 2) begin
            bus4.in_valid = 1'b0;
            bus4.in = 32'hFFFF_FFFF;
            tick();
         end
      end
      bus4.in_valid = 1'b0;
      for (int i = 0; i < 40; i++) tick();
      chk("dec_count", 32'(rx4_q.size()), 32'd3);
      for (int k = 0; k < 3; k++) begin
         if (k < rx4_q.size()) chk($sformatf("dec_w%0d", k), rx4_q[k], 32'(4 * k + 1));
      end
      chk("dec_drop", 32'(drop_cnt4), 32'd0);

      // Reset in the middle of a word, with a second word queued.
      bus.tx_ready = 1'b1;
      bus.in = 32'hCAFE_F00D;
      bus.in_valid = 1'b1;
      tick();
      bus.in = 32'h1234_5678;
      tick();
      bus.in_valid = 1'b0;
      chk("mid_b0", 32'(bus.tx_data), 32'hCA);
      tick();
      chk("mid_b1", 32'(bus.tx_data), 32'hFE);
      tick();
      chk("mid_b2", 32'(bus.tx_data), 32'hF0);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.tx_valid), 32'd0);
      chk("arst_data", 32'(bus.tx_data), 32'd0);
      chk("arst_last", 32'(bus.tx_last), 32'd0);
      chk("arst_fill", 32'(fill), 32'd0);
      tick();
      rst = 1'b1;
      bus.tx_ready = 1'b0;
      tick();
      bus.in = 32'h0BAD_BEEF;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      drain(100, nb);
      chk("post_rst_words", 32'(rx_q.size()), 32'd1);
      if (rx_q.size() > 0) chk("post_rst_w0", rx_q[0], 32'h0BAD_BEEF);
      chk("post_rst_bytes", 32'(nb), 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
